// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 block: register addresses,
// exception codes and SR/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_SR       = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int SR_IM_LO  = 8;
    localparam int IP_SW_LO  = 8;
    localparam int IP_HW_LO  = 10;
    localparam int EXC_LO    = 2;
    localparam int CAUSE_TI  = 30;
    localparam int CAUSE_BD  = 31;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled 32-bit Count, Compare register and the
// sticky TI flag raised one cycle after Count matches Compare.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;
    logic          wrap;

    assign wrap = (presc_q == PW'(COUNT_DIV - 1));

    always_comb begin
        presc_d   = wrap ? '0 : presc_q + 1'b1;
        count_d   = count_q + 32'(wrap);
        compare_d = compare_q;
        ti_d      = ti_q | (count_q == compare_q);
        // A software load of Count restarts the prescale period.
        if (wr_count) begin
            count_d = wdata;
            presc_d = '0;
        end
        if (wr_compare) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_ext.sv
// Coprocessor 0 beside the M stage: SR/Cause/EPC/BadVAddr/PRId, interrupt and
// exception arbitration into Req. Define CP0_TIMER_EN to build the Count/Compare timer.
module cp0_ext
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT  = 6,
    parameter int          TIMER_LINE = 5,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [4:0]           CP0addr,
    input  logic [31:0]          CP0in,
    input  logic [31:0]          VPC,
    input  logic                 BDin,
    input  logic [4:0]           ExcCodeIn,
    input  logic [31:0]          BadVAddrIn,
    input  logic [NUM_HWINT-1:0] HWInt,
    input  logic                 EXLclr,
    output logic [31:0]          CP0out,
    output logic [31:0]          EPCout,
    output logic                 Req,
    output logic                 TimerIrq
);

    logic [7:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_q, exc_d;
    logic [1:0]  ipsw_q, ipsw_d;
    logic [5:0]  iphw_q;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badva_q, badva_d;

    logic [31:0] tmr_count, tmr_compare;
    logic        ti;
    logic [5:0]  hw_ext, hw_pend;
    logic        int_req, exc_req;

`ifdef CP0_TIMER_EN
    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_count   (en && (CP0addr == ADDR_COUNT)),
        .wr_compare (en && (CP0addr == ADDR_COMPARE)),
        .wdata      (CP0in),
        .count      (tmr_count),
        .compare    (tmr_compare),
        .ti         (ti)
    );
`else
    logic [31:0] unused_count_div;
    assign unused_count_div = COUNT_DIV;
    assign tmr_count   = '0;
    assign tmr_compare = '0;
    assign ti          = 1'b0;
`endif

    always_comb begin
        hw_ext                 = '0;
        hw_ext[NUM_HWINT-1:0]  = HWInt;
        hw_pend                = hw_ext | (6'(ti) << TIMER_LINE);
    end

    // Live HWInt feeds arbitration directly; Cause.IP only shows it a cycle later.
    assign int_req  = (|({hw_pend, ipsw_q} & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req  = (ExcCodeIn != EXC_INT) & ~sr_exl_q;
    assign Req      = (int_req | exc_req) & ~EXLclr & reset_n;
    assign EPCout   = epc_q;
    assign TimerIrq = ti;

    always_comb begin
        sr_im_d  = sr_im_q;
        sr_exl_d = sr_exl_q;
        sr_ie_d  = sr_ie_q;
        bd_d     = bd_q;
        exc_d    = exc_q;
        ipsw_d   = ipsw_q;
        epc_d    = epc_q;
        badva_d  = badva_q;
        if (en) begin
            case (CP0addr)
                ADDR_SR: begin
                    sr_im_d  = CP0in[SR_IM_LO +: 8];
                    sr_exl_d = CP0in[SR_EXL];
                    sr_ie_d  = CP0in[SR_IE];
                end
                ADDR_CAUSE: ipsw_d = CP0in[IP_SW_LO +: 2];
                ADDR_EPC:   epc_d  = CP0in;
                default:    ;
            endcase
        end
        if (Req) begin
            sr_exl_d = 1'b1;
            bd_d     = BDin;
            exc_d    = int_req ? EXC_INT : ExcCodeIn;
            epc_d    = BDin ? VPC - 32'd4 : VPC;
            if (!int_req && (ExcCodeIn == EXC_ADEL || ExcCodeIn == EXC_ADES))
                badva_d = BadVAddrIn;
        end
        if (EXLclr)
            sr_exl_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_im_q  <= '0;
            sr_exl_q <= 1'b0;
            sr_ie_q  <= 1'b0;
            bd_q     <= 1'b0;
            exc_q    <= '0;
            ipsw_q   <= '0;
            iphw_q   <= '0;
            epc_q    <= '0;
            badva_q  <= '0;
        end else begin
            sr_im_q  <= sr_im_d;
            sr_exl_q <= sr_exl_d;
            sr_ie_q  <= sr_ie_d;
            bd_q     <= bd_d;
            exc_q    <= exc_d;
            ipsw_q   <= ipsw_d;
            iphw_q   <= hw_ext;
            epc_q    <= epc_d;
            badva_q  <= badva_d;
        end
    end

    // mfc0 returns pre-write state; a same-cycle mtc0 is not forwarded.
    always_comb begin
        CP0out = '0;
        case (CP0addr)
            ADDR_BADVADDR: CP0out = badva_q;
            ADDR_COUNT:    CP0out = tmr_count;
            ADDR_COMPARE:  CP0out = tmr_compare;
            ADDR_SR: begin
                CP0out[SR_IM_LO +: 8] = sr_im_q;
                CP0out[SR_EXL]        = sr_exl_q;
                CP0out[SR_IE]         = sr_ie_q;
            end
            ADDR_CAUSE: begin
                CP0out[CAUSE_BD]      = bd_q;
                CP0out[CAUSE_TI]      = ti;
                CP0out[IP_HW_LO +: 6] = iphw_q;
                CP0out[IP_SW_LO +: 2] = ipsw_q;
                CP0out[EXC_LO +: 5]   = exc_q;
            end
            ADDR_EPC:      CP0out = epc_q;
            ADDR_PRID:     CP0out = PRID_VAL;
            default:       ;
        endcase
    end

endmodule

// File: tb/tb_cp0_ext.sv
// Bench for cp0_ext: directed scenarios plus randomized traffic, all checked
// against a word-level behavioural model of the coprocessor state.
module tb_cp0_ext;

    localparam int          TIMER_LINE = 5;
    localparam int          COUNT_DIV  = 2;
    localparam logic [31:0] PRID       = 32'h0000_4220;

    logic        clk = 1'b0;
    logic        reset_n, en, BDin, EXLclr;
    logic [4:0]  CP0addr, ExcCodeIn;
    logic [31:0] CP0in, VPC, BadVAddrIn;
    logic [5:0]  HWInt;
    logic [31:0] CP0out, EPCout;
    logic        Req, TimerIrq;

    cp0_ext #(.NUM_HWINT(6), .TIMER_LINE(TIMER_LINE), .COUNT_DIV(COUNT_DIV), .PRID_VAL(PRID)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .CP0addr(CP0addr), .CP0in(CP0in),
        .VPC(VPC), .BDin(BDin), .ExcCodeIn(ExcCodeIn), .BadVAddrIn(BadVAddrIn),
        .HWInt(HWInt), .EXLclr(EXLclr), .CP0out(CP0out), .EPCout(EPCout),
        .Req(Req), .TimerIrq(TimerIrq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference state held as architectural 32-bit words.
    logic [31:0] m_sr, m_cause, m_epc, m_bad, m_count, m_cmp;
    logic        m_ti;
    int          m_phase;

    task automatic m_reset();
        m_sr = 0; m_cause = 0; m_epc = 0; m_bad = 0;
        m_count = 0; m_cmp = 0; m_ti = 0; m_phase = 0;
    endtask

    function automatic logic m_intreq();
        logic [31:0] pend;
        pend = ({26'b0, HWInt} | (32'(m_ti) << TIMER_LINE)) << 10;
        pend = pend | (m_cause & 32'h0000_0300);
        return (|(pend & m_sr & 32'h0000_FF00)) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return reset_n && !EXLclr && (m_intreq() || (ExcCodeIn != 5'd0 && !m_sr[1]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_bad;
            5'd9:  return m_count;
            5'd11: return m_cmp;
            5'd12: return m_sr;
            5'd13: return m_cause | (32'(m_ti) << 30);
            5'd14: return m_epc;
            5'd15: return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step();
        logic        ir, rq;
        logic [31:0] n_sr, n_cause, n_epc, n_bad;
        ir = m_intreq();
        rq = m_req();
        n_sr = m_sr; n_cause = m_cause; n_epc = m_epc; n_bad = m_bad;
        if (en && CP0addr == 5'd12) n_sr = CP0in & 32'h0000_FF03;
        if (en && CP0addr == 5'd13) n_cause = (m_cause & ~32'h300) | (CP0in & 32'h300);
        if (en && CP0addr == 5'd14) n_epc = CP0in;
        if (rq) begin
            n_sr[1] = 1'b1;
            n_cause[31] = BDin;
            n_cause[6:2] = ir ? 5'd0 : ExcCodeIn;
            n_epc = BDin ? VPC - 4 : VPC;
            if (!ir && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5)) n_bad = BadVAddrIn;
        end
        if (EXLclr) n_sr[1] = 1'b0;
        n_cause[15:10] = HWInt;
`ifdef CP0_TIMER_EN
        m_ti = (en && CP0addr == 5'd11) ? 1'b0 : (m_ti || m_count == m_cmp);
        if (en && CP0addr == 5'd11) m_cmp = CP0in;
        if (en && CP0addr == 5'd9) begin
            m_count = CP0in;
            m_phase = 0;
        end else if (m_phase == COUNT_DIV - 1) begin
            m_count = m_count + 1;
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
`endif
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc; m_bad = n_bad;
    endtask

    // One clock: compare outputs to the model, then advance both.
    task automatic cycle();
        #1;
        chk("req", 32'(Req), 32'(m_req()));
        chk("epc", EPCout, m_epc);
        chk("tirq", 32'(TimerIrq), 32'(m_ti));
        chk("rd", CP0out, m_read(CP0addr));
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] mask, input logic [31:0] exp, input string tag);
        CP0addr = a;
        #1;
        chk(tag, CP0out & mask, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        en = 1'b1; CP0addr = a; CP0in = d;
        cycle();
        en = 1'b0;
    endtask

    logic [4:0] addr_tab [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    logic [4:0] code_tab [5] = '{5'd4, 5'd5, 5'd8, 5'd10, 5'd12};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 0; en = 0; BDin = 0; EXLclr = 0; CP0addr = 0; ExcCodeIn = 0;
        CP0in = 0; VPC = 0; BadVAddrIn = 0; HWInt = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(Req), 0);
        chk("rst_epc", EPCout, 0);
        chk("rst_tirq", 32'(TimerIrq), 0);
        rd(5'd13, 32'hFFFF_FFFF, 0, "rst_cause");
        reset_n = 1;
        rd(5'd15, 32'hFFFF_FFFF, PRID, "prid");
        rd(5'd12, 32'hFFFF_FFFF, 0, "sr0");
        rd(5'd14, 32'hFFFF_FFFF, 0, "epc0");
        chk("req0", 32'(Req), 0);
        cycle();

        // HW interrupt in a delay slot
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'd1; VPC = 32'h3000; BDin = 1;
        #1 chk("hw_req", 32'(Req), 1);
        cycle();
        rd(5'd14, 32'hFFFF_FFFF, 32'h2FFC, "hw_epc");
        rd(5'd13, 32'hBFFF_FFFF, 32'h8000_0400, "hw_cause");
        rd(5'd12, 32'hFFFF_FFFF, 32'h0000_0403, "hw_sr");
        HWInt = 0; BDin = 0; EXLclr = 1;
        cycle();
        EXLclr = 0;
        rd(5'd12, 32'hFFFF_FFFF, 32'h0000_0401, "eret_sr");

        // Address error exception
        mtc0(5'd12, 32'h0);
        ExcCodeIn = 5'd4; BadVAddrIn = 32'h1001; VPC = 32'h4000;
        #1 chk("ade_req", 32'(Req), 1);
        cycle();
        ExcCodeIn = 0;
        rd(5'd8, 32'hFFFF_FFFF, 32'h1001, "ade_bad");
        rd(5'd13, 32'hBFFF_FFFF, 32'h0000_0010, "ade_cause");
        rd(5'd14, 32'hFFFF_FFFF, 32'h4000, "ade_epc");
        EXLclr = 1;
        cycle();
        EXLclr = 0;

        // eret racing a new exception
        ExcCodeIn = 5'd12; VPC = 32'h5000;
        cycle();
        VPC = 32'h6000; EXLclr = 1;
        #1 chk("eret_req", 32'(Req), 0);
        cycle();
        EXLclr = 0; ExcCodeIn = 0;
        rd(5'd12, 32'h0000_0002, 0, "eret_exl");
        chk("eret_epc", EPCout, 32'h5000);

        // Software interrupt
        mtc0(5'd12, 32'h0000_0101);
        en = 1; CP0addr = 5'd13; CP0in = 32'h0000_0100;
        #1 chk("sw_req_same", 32'(Req), 0);
        cycle();
        en = 0;
        #1 chk("sw_req", 32'(Req), 1);
        cycle();
        rd(5'd13, 32'h0000_FF7C, 32'h0000_0100, "sw_cause");
        rd(5'd12, 32'h0000_0002, 32'h2, "sw_exl");
        mtc0(5'd13, 32'h0);
        EXLclr = 1;
        cycle();
        EXLclr = 0;
        mtc0(5'd12, 32'h0);

        // Asynchronous reset in the middle of a handler
        ExcCodeIn = 5'd12; VPC = 32'h7000;
        cycle();
        #2 reset_n = 0;
        m_reset();
        #1;
        chk("mid_rst_epc", EPCout, 0);
        chk("mid_rst_req", 32'(Req), 0);
        rd(5'd12, 32'hFFFF_FFFF, 0, "mid_rst_sr");
        ExcCodeIn = 0;
        @(posedge clk);
        #1;
        chk("mid_rst_req2", 32'(Req), 0);
        reset_n = 1;
        cycle();

`ifdef CP0_TIMER_EN
        begin
            int n;
            mtc0(5'd9, 32'd0);
            mtc0(5'd11, 32'd10);
            mtc0(5'd12, 32'h0000_8001);
            n = 2;
            while (!TimerIrq && n < 40) begin
                cycle();
                n++;
            end
            chk("ti_lat", 32'(n), 32'd21);
            #1 chk("ti_req", 32'(Req), 1);
            cycle();
            mtc0(5'd11, 32'h100);
            chk("ti_clr", 32'(TimerIrq), 0);
            EXLclr = 1;
            cycle();
            EXLclr = 0;
            mtc0(5'd12, 32'h0);
        end
`else
        mtc0(5'd9, 32'h0000_FFFF);
        mtc0(5'd11, 32'd5);
        rd(5'd9, 32'hFFFF_FFFF, 0, "cnt_off");
        rd(5'd11, 32'hFFFF_FFFF, 0, "cmp_off");
        chk("tirq_off", 32'(TimerIrq), 0);
`endif

        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(3) == 0);
            CP0addr = addr_tab[$urandom_range(7)];
            CP0in = $urandom;
            ExcCodeIn = ($urandom_range(6) == 0) ? code_tab[$urandom_range(4)] : 5'd0;
            if ($urandom_range(3) == 0) HWInt = 6'($urandom);
            VPC = $urandom & 32'hFFFF_FFFC;
            BDin = 1'($urandom_range(1));
            BadVAddrIn = $urandom;
            EXLclr = ($urandom_range(5) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
